// File: rtl/spi_flash_mux_n_if.sv
// Host/flash pin groups and control for the N-channel SPI flash router.
// master drives host pins, flash MISO and selection; slave is the router.
interface spi_flash_mux_n_if #(
    parameter int N_FLASH = 2,
    parameter int IDX_W   = 1,
    parameter int CNT_W   = 16
);
    logic               h_clk;
    logic               h_cs_n;
    logic               h_mosi;
    logic               h_miso;
    logic [N_FLASH-1:0] f_clk;
    logic [N_FLASH-1:0] f_cs_n;
    logic [N_FLASH-1:0] f_mosi;
    logic [N_FLASH-1:0] f_miso;
    logic [N_FLASH-1:0] sel_mask;
    logic [IDX_W-1:0]   rd_sel;
    logic [N_FLASH-1:0] active_mask;
    logic [IDX_W-1:0]   active_rd_sel;
    logic               mode_switch_pending;
    logic [CNT_W-1:0]   txn_count;
    logic               cmp_clr;
    logic               cmp_mismatch;

    modport master (
        output h_clk, h_cs_n, h_mosi, f_miso, sel_mask, rd_sel, cmp_clr,
        input  h_miso, f_clk, f_cs_n, f_mosi, active_mask, active_rd_sel,
        input  mode_switch_pending, txn_count, cmp_mismatch
    );

    modport slave (
        input  h_clk, h_cs_n, h_mosi, f_miso, sel_mask, rd_sel, cmp_clr,
        output h_miso, f_clk, f_cs_n, f_mosi, active_mask, active_rd_sel,
        output mode_switch_pending, txn_count, cmp_mismatch
    );
endinterface

// File: rtl/spi_flash_mux_n.sv
// N-channel SPI flash router with guarded mask switching and txn counting.
// Define FLASH_MUX_MISO_CMP_EN to enable mirrored-MISO cross-checking.
module spi_flash_mux_n #(
    parameter int N_FLASH      = 2,
    parameter int IDX_W        = 1,
    parameter int GUARD_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input logic             clk,
    input logic             rst,
    spi_flash_mux_n_if.slave bus
);
    localparam int G_W = $clog2(GUARD_CYCLES + 1);
    localparam int NP  = 2 ** IDX_W;

    typedef enum logic [1:0] {IDLE, ACTIVE, GUARD} state_t;

    state_t             state;
    logic [G_W-1:0]     g_cnt;
    logic [1:0]         cs_sync;
    logic               cs_s;
    logic [N_FLASH-1:0] active_mask;
    logic [IDX_W-1:0]   active_rd_sel;
    logic               pending;
    logic [CNT_W-1:0]   txn_count;
    logic               rd_ok;
    logic               diff;
    logic               apply;
    logic [NP-1:0]      mask_pad;
    logic [NP-1:0]      miso_pad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cs_sync <= 2'b11;
        else     cs_sync <= {cs_sync[0], bus.h_cs_n};
    end
    assign cs_s = cs_sync[1];

    // Out-of-range read index is never applied, so it must not count as a diff
    assign rd_ok = int'(bus.rd_sel) < N_FLASH;
    assign diff  = (bus.sel_mask != active_mask) ||
                   (rd_ok && (bus.rd_sel != active_rd_sel));
    assign apply = (state == IDLE) && bus.h_cs_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            g_cnt         <= '0;
            active_mask   <= N_FLASH'(1);
            active_rd_sel <= '0;
            pending       <= 1'b0;
            txn_count     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!cs_s) begin
                        state     <= ACTIVE;
                        txn_count <= txn_count + CNT_W'(1);
                    end
                end
                ACTIVE: begin
                    if (cs_s) begin
                        state <= GUARD;
                        g_cnt <= '0;
                    end
                end
                GUARD: begin
                    if (!cs_s) begin
                        state     <= ACTIVE;
                        txn_count <= txn_count + CNT_W'(1);
                    end else if (g_cnt == G_W'(GUARD_CYCLES - 1)) begin
                        state <= IDLE;
                    end else begin
                        g_cnt <= g_cnt + G_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            if (apply) begin
                active_mask <= bus.sel_mask;
                if (rd_ok) active_rd_sel <= bus.rd_sel;
                pending <= 1'b0;
            end else if (state != IDLE && diff) begin
                pending <= 1'b1;
            end
        end
    end

    assign bus.f_clk  = active_mask & {N_FLASH{bus.h_clk}};
    assign bus.f_cs_n = ~active_mask | {N_FLASH{bus.h_cs_n}};
    assign bus.f_mosi = active_mask & {N_FLASH{bus.h_mosi}};

    assign mask_pad   = NP'(active_mask);
    assign miso_pad   = NP'(bus.f_miso);
    assign bus.h_miso = mask_pad[active_rd_sel] & miso_pad[active_rd_sel];

    assign bus.active_mask         = active_mask;
    assign bus.active_rd_sel       = active_rd_sel;
    assign bus.mode_switch_pending = pending;
    assign bus.txn_count           = txn_count;

`ifdef FLASH_MUX_MISO_CMP_EN
    logic [2:0]         hclk_sync;
    logic [N_FLASH-1:0] miso_s1;
    logic [N_FLASH-1:0] miso_s2;
    logic               mismatch;
    logic               hclk_rise;
    logic               disagree;

    assign hclk_rise = hclk_sync[1] & ~hclk_sync[2];
    // A 1 and a 0 among enabled channels needs at least two enabled
    assign disagree  = (|(active_mask & miso_s2)) &&
                       (|(active_mask & ~miso_s2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hclk_sync <= '0;
            miso_s1   <= '0;
            miso_s2   <= '0;
            mismatch  <= 1'b0;
        end else begin
            hclk_sync <= {hclk_sync[1:0], bus.h_clk};
            miso_s1   <= bus.f_miso;
            miso_s2   <= miso_s1;
            if (state == ACTIVE && hclk_rise && disagree) mismatch <= 1'b1;
            else if (bus.cmp_clr)                          mismatch <= 1'b0;
        end
    end
    assign bus.cmp_mismatch = mismatch;
`else
    logic unused_cmp_clr;
    assign unused_cmp_clr   = bus.cmp_clr;
    assign bus.cmp_mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_spi_flash_mux_n.sv
// Directed bench for spi_flash_mux_n with N_FLASH=4, IDX_W=3, GUARD_CYCLES=4,
// CNT_W=4; expected compare result follows FLASH_MUX_MISO_CMP_EN.
module tb_spi_flash_mux_n;
    localparam int N  = 4;
    localparam int IW = 3;
    localparam int GC = 4;
    localparam int CW = 4;
`ifdef FLASH_MUX_MISO_CMP_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    spi_flash_mux_n_if #(.N_FLASH(N), .IDX_W(IW), .CNT_W(CW)) bus ();

    spi_flash_mux_n #(
        .N_FLASH(N), .IDX_W(IW), .GUARD_CYCLES(GC), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        n_chk++;
        if (bus.active_mask !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_mask: got %b want 0001", bus.active_mask);
        end
        n_chk++;
        if (bus.active_rd_sel !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_rd_sel: got %0d want 0", bus.active_rd_sel);
        end
        n_chk++;
        if (bus.mode_switch_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pending: got %b want 0", bus.mode_switch_pending);
        end
        n_chk++;
        if (bus.txn_count !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_txn: got %0d want 0", bus.txn_count);
        end
        n_chk++;
        if (bus.cmp_mismatch !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_cmp: got %b want 0", bus.cmp_mismatch);
        end
    endtask

    task automatic test_route;
        bus.h_cs_n = 1'b0;
        tick(2);
        n_chk++;
        if (bus.txn_count !== 4'd0) begin
            n_fail++;
            $display("FAIL txn_early: got %0d want 0", bus.txn_count);
        end
        tick();
        n_chk++;
        if (bus.txn_count !== 4'd1) begin
            n_fail++;
            $display("FAIL txn_first: got %0d want 1", bus.txn_count);
        end
        bus.h_clk  = 1'b1;
        bus.h_mosi = 1'b1;
        #1;
        n_chk++;
        if (bus.f_clk !== 4'b0001 || bus.f_mosi !== 4'b0001) begin
            n_fail++;
            $display("FAIL route_clk_mosi: got %b/%b want 0001/0001",
                     bus.f_clk, bus.f_mosi);
        end
        n_chk++;
        if (bus.f_cs_n !== 4'b1110) begin
            n_fail++;
            $display("FAIL route_cs: got %b want 1110", bus.f_cs_n);
        end
        bus.f_miso = 4'b0001;
        #1;
        n_chk++;
        if (bus.h_miso !== 1'b1) begin
            n_fail++;
            $display("FAIL miso_ch0_hi: got %b want 1", bus.h_miso);
        end
        bus.f_miso = 4'b1110;
        #1;
        n_chk++;
        if (bus.h_miso !== 1'b0) begin
            n_fail++;
            $display("FAIL miso_ch0_lo: got %b want 0", bus.h_miso);
        end
        bus.h_clk  = 1'b0;
        bus.h_mosi = 1'b0;
        bus.f_miso = 4'b0000;
    endtask

    task automatic test_switch;
        bus.sel_mask = 4'b0110;
        tick();
        n_chk++;
        if (bus.mode_switch_pending !== 1'b1 || bus.active_mask !== 4'b0001) begin
            n_fail++;
            $display("FAIL sw_pending: got p=%b m=%b want p=1 m=0001",
                     bus.mode_switch_pending, bus.active_mask);
        end
        bus.h_cs_n = 1'b1;
        tick(GC + 3);
        n_chk++;
        if (bus.active_mask !== 4'b0001 || bus.mode_switch_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_too_early: got m=%b p=%b want m=0001 p=1",
                     bus.active_mask, bus.mode_switch_pending);
        end
        tick();
        n_chk++;
        if (bus.active_mask !== 4'b0110 || bus.mode_switch_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_apply: got m=%b p=%b want m=0110 p=0",
                     bus.active_mask, bus.mode_switch_pending);
        end
    endtask

    task automatic test_rd_sel;
        bus.rd_sel = 3'd5;
        tick();
        n_chk++;
        if (bus.active_rd_sel !== 3'd0 || bus.mode_switch_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_illegal: got sel=%0d p=%b want sel=0 p=0",
                     bus.active_rd_sel, bus.mode_switch_pending);
        end
        bus.sel_mask = 4'b0100;
        bus.rd_sel   = 3'd2;
        tick();
        n_chk++;
        if (bus.active_rd_sel !== 3'd2 || bus.active_mask !== 4'b0100) begin
            n_fail++;
            $display("FAIL rd_apply: got sel=%0d m=%b want sel=2 m=0100",
                     bus.active_rd_sel, bus.active_mask);
        end
        bus.f_miso = 4'b0100;
        #1;
        n_chk++;
        if (bus.h_miso !== 1'b1) begin
            n_fail++;
            $display("FAIL miso_ch2_hi: got %b want 1", bus.h_miso);
        end
        bus.f_miso = 4'b1011;
        #1;
        n_chk++;
        if (bus.h_miso !== 1'b0) begin
            n_fail++;
            $display("FAIL miso_ch2_lo: got %b want 0", bus.h_miso);
        end
        bus.sel_mask = 4'b0000;
        tick();
        bus.f_miso = 4'b1111;
        #1;
        n_chk++;
        if (bus.h_miso !== 1'b0 || bus.active_mask !== 4'b0000) begin
            n_fail++;
            $display("FAIL mask_zero: got miso=%b m=%b want 0/0000",
                     bus.h_miso, bus.active_mask);
        end
        bus.h_cs_n = 1'b0;
        tick(3);
        n_chk++;
        if (bus.txn_count !== 4'd2 || bus.f_cs_n !== 4'b1111) begin
            n_fail++;
            $display("FAIL txn_mask_zero: got cnt=%0d cs=%b want 2/1111",
                     bus.txn_count, bus.f_cs_n);
        end
        bus.h_cs_n = 1'b1;
        bus.f_miso = 4'b0000;
        tick(GC + 4);
    endtask

    task automatic test_short_gap;
        bus.sel_mask = 4'b0110;
        bus.rd_sel   = 3'd1;
        tick();
        bus.h_cs_n = 1'b0;
        tick(3);
        bus.sel_mask = 4'b0011;
        tick();
        bus.h_cs_n = 1'b1;
        tick(2);
        bus.h_cs_n = 1'b0;
        tick(6);
        n_chk++;
        if (bus.mode_switch_pending !== 1'b1 || bus.active_mask !== 4'b0110) begin
            n_fail++;
            $display("FAIL gap_hold: got p=%b m=%b want p=1 m=0110",
                     bus.mode_switch_pending, bus.active_mask);
        end
        n_chk++;
        if (bus.txn_count !== 4'd4) begin
            n_fail++;
            $display("FAIL gap_txn: got %0d want 4", bus.txn_count);
        end
        bus.h_cs_n = 1'b1;
        tick(GC + 4);
        n_chk++;
        if (bus.active_mask !== 4'b0011 || bus.mode_switch_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_apply: got m=%b p=%b want m=0011 p=0",
                     bus.active_mask, bus.mode_switch_pending);
        end
    endtask

    task automatic test_reset_mid;
        bus.sel_mask = 4'b0110;
        tick();
        bus.h_cs_n = 1'b0;
        tick(3);
        bus.h_clk = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        n_chk++;
        if (bus.f_cs_n !== 4'b1110 || bus.f_clk !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_mid_route: got cs=%b clk=%b want 1110/0001",
                     bus.f_cs_n, bus.f_clk);
        end
        n_chk++;
        if (bus.txn_count !== 4'd0 || bus.active_mask !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_mid_state: got cnt=%0d m=%b want 0/0001",
                     bus.txn_count, bus.active_mask);
        end
        bus.h_clk    = 1'b0;
        bus.h_cs_n   = 1'b1;
        bus.sel_mask = 4'b0001;
        bus.rd_sel   = 3'd0;
        tick(2);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 15; i++) begin
            bus.h_cs_n = 1'b0;
            tick(3);
            bus.h_cs_n = 1'b1;
            tick(GC + 4);
        end
        n_chk++;
        if (bus.txn_count !== 4'd15) begin
            n_fail++;
            $display("FAIL txn_full: got %0d want 15", bus.txn_count);
        end
        bus.h_cs_n = 1'b0;
        tick(3);
        n_chk++;
        if (bus.txn_count !== 4'd0) begin
            n_fail++;
            $display("FAIL txn_wrap: got %0d want 0", bus.txn_count);
        end
        bus.h_cs_n = 1'b1;
        tick(GC + 4);
    endtask

    task automatic test_cmp;
        bus.sel_mask = 4'b0011;
        tick();
        bus.h_cs_n = 1'b0;
        tick(3);
        bus.f_miso = 4'b0001;
        tick(3);
        bus.h_clk = 1'b1;
        tick(4);
        n_chk++;
        if (bus.cmp_mismatch !== CMP) begin
            n_fail++;
            $display("FAIL cmp_set: got %b want %b", bus.cmp_mismatch, CMP);
        end
        bus.h_clk = 1'b0;
        tick(3);
        n_chk++;
        if (bus.cmp_mismatch !== CMP) begin
            n_fail++;
            $display("FAIL cmp_sticky: got %b want %b", bus.cmp_mismatch, CMP);
        end
        bus.cmp_clr = 1'b1;
        tick();
        bus.cmp_clr = 1'b0;
        tick();
        n_chk++;
        if (bus.cmp_mismatch !== 1'b0) begin
            n_fail++;
            $display("FAIL cmp_clr: got %b want 0", bus.cmp_mismatch);
        end
        bus.f_miso = 4'b0011;
        tick(3);
        bus.h_clk = 1'b1;
        tick(4);
        n_chk++;
        if (bus.cmp_mismatch !== 1'b0) begin
            n_fail++;
            $display("FAIL cmp_agree: got %b want 0", bus.cmp_mismatch);
        end
        bus.h_clk = 1'b0;
        tick(3);
        bus.f_miso = 4'b0001;
        bus.h_clk  = 1'b1;
        tick(2);
        bus.cmp_clr = 1'b1;
        tick();
        bus.cmp_clr = 1'b0;
        n_chk++;
        if (bus.cmp_mismatch !== CMP) begin
            n_fail++;
            $display("FAIL cmp_set_wins: got %b want %b", bus.cmp_mismatch, CMP);
        end
        bus.h_clk  = 1'b0;
        bus.h_cs_n = 1'b1;
        bus.f_miso = 4'b0000;
        tick(GC + 4);
    endtask

    initial begin
        rst          = 1'b1;
        bus.h_clk    = 1'b0;
        bus.h_cs_n   = 1'b1;
        bus.h_mosi   = 1'b0;
        bus.f_miso   = 4'b0000;
        bus.sel_mask = 4'b0001;
        bus.rd_sel   = 3'd0;
        bus.cmp_clr  = 1'b0;
        tick(3);
        rst = 1'b0;
        tick();
        test_reset();
        test_route();
        test_switch();
        test_rd_sel();
        test_short_gap();
        test_reset_mid();
        test_wrap();
        test_cmp();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
